// File: rtl/spi_mem_bridge_pkg.sv
// Shared types for the SPI-to-memory bridge: FSM states, command frame layout
// and memory op encodings.
package spi_mem_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE, WR_DATA, WR_REQ, GO_SET, RD_REQ, RD_RESP, RD_HOLD
   } state_t;

   localparam int CMD_LEN_MSB = 30;
   localparam int CMD_LEN_LSB = 24;
   localparam int CMD_ADDR_W  = 24;

   // Command frame: [31] read, [30:24] len-1, [23:0] byte address
   typedef struct packed {
      logic                             rd;
      logic [CMD_LEN_MSB-CMD_LEN_LSB:0] len_m1;
      logic [CMD_ADDR_W-1:0]            addr;
   } cmd_t;

   localparam logic        MEM_OP_RD     = 1'b0;
   localparam logic        MEM_OP_WR     = 1'b1;
   localparam logic [31:0] UNDERRUN_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/spi_mem_bridge_minion.sv
// SPI minion (mode 0): samples cs/sclk/mosi into clk, shifts frames in/out.
// pull_en fires at frame start (cs fall), push_en at frame end (cs rise).
module spi_mem_bridge_minion #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cs,
   input  logic               sclk,
   input  logic               mosi,
   output logic               miso,
   output logic               pull_en,
   input  logic [p_nbits-1:0] pull_msg,
   output logic               push_en,
   output logic [p_nbits-1:0] push_msg
);

   logic [2:0]         cs_q, sclk_q;
   logic [1:0]         mosi_q;
   logic [p_nbits-1:0] tx, rx;
   logic               sclk_rise, sclk_fall;

   always_comb begin
      pull_en   = cs_q[2] & ~cs_q[1];
      push_en   = ~cs_q[2] & cs_q[1];
      sclk_rise = ~cs_q[1] & ~sclk_q[2] & sclk_q[1];
      sclk_fall = ~cs_q[1] & sclk_q[2] & ~sclk_q[1];
      miso      = tx[p_nbits-1];
      push_msg  = rx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q   <= 3'b111;
         sclk_q <= 3'b000;
         mosi_q <= 2'b00;
         tx     <= '0;
         rx     <= '0;
      end else begin
         cs_q   <= {cs_q[1:0], cs};
         sclk_q <= {sclk_q[1:0], sclk};
         mosi_q <= {mosi_q[0], mosi};
         if (pull_en)
            tx <= pull_msg;
         else if (sclk_fall)
            tx <= {tx[p_nbits-2:0], 1'b0};
         // mosi_q[1] has the same synchroniser delay as sclk_q[1]
         if (sclk_rise)
            rx <= {rx[p_nbits-2:0], mosi_q[1]};
      end
   end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI command/data frames translated into single-outstanding 32-bit memory
// bursts, with a processor-enable register and sticky error status.
module spi_mem_bridge
   import spi_mem_bridge_pkg::*;
#(
   parameter int          p_opaq_bits = 8,
   parameter int          p_max_burst = 16,
   parameter logic [31:0] p_go_addr   = 32'h00000000,
   parameter logic [31:0] p_stat_addr = 32'h00000004
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cs,
   input  logic                   mosi,
   input  logic                   sclk,
   output logic                   miso,
   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic                   mem_req_op,
   output logic [p_opaq_bits-1:0] mem_req_opaque,
   output logic [31:0]            mem_req_addr,
   output logic [3:0]             mem_req_strb,
   output logic [31:0]            mem_req_data,
   input  logic                   mem_resp_val,
   output logic                   mem_resp_rdy,
   input  logic [31:0]            mem_resp_data,
   output logic                   go,
   output logic [2:0]             err
);

   localparam int CW = (p_max_burst > 1) ? $clog2(p_max_burst) : 1;

   state_t        state;
   cmd_t          cmd;
   logic          pull_en, push_en, fin;
   logic [31:0]   pull_msg, push_msg, wr_data, rd_buf, cur_addr;
   logic [23:0]   base;
   logic [CW-1:0] len_m1, idx, fcnt;
   logic          is_go, is_stat, last, rd_state;
   logic [2:0]    err_set, err_clr;

   spi_mem_bridge_minion #(.p_nbits(32)) u_minion (
      .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
      .pull_en(pull_en), .pull_msg(pull_msg),
      .push_en(push_en), .push_msg(push_msg)
   );

   always_comb begin
      cmd      = cmd_t'(push_msg);
      cur_addr = {8'd0, base + {22'(idx), 2'b00}};
      is_go    = (cur_addr == p_go_addr);
      is_stat  = (cur_addr == p_stat_addr);
      last     = (idx == len_m1);
      rd_state = (state == RD_REQ) || (state == RD_RESP) || (state == RD_HOLD);
      err_set    = '0;
      err_set[0] = push_en && (state == WR_REQ);
      err_set[1] = pull_en && ((state == RD_REQ) || (state == RD_RESP));
      err_set[2] = push_en && (state == IDLE) &&
                   ({25'd0, cmd.len_m1} >= 32'(p_max_burst));
      err_clr  = (push_en && state == WR_DATA && is_stat) ? push_msg[2:0] : 3'b000;
      case (state)
         IDLE:             pull_msg = {29'd0, err};
         RD_REQ, RD_RESP:  pull_msg = UNDERRUN_WORD;
         default:          pull_msg = rd_buf;
      endcase
      mem_req_op    = (state == RD_REQ) ? MEM_OP_RD : MEM_OP_WR;
      mem_req_addr  = cur_addr;
      mem_req_strb  = 4'b1111;
      mem_req_data  = wr_data;
      mem_resp_rdy  = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         go             <= 1'b1;
         err            <= '0;
         rd_buf         <= '0;
         wr_data        <= '0;
         base           <= '0;
         len_m1         <= '0;
         idx            <= '0;
         fcnt           <= '0;
         fin            <= 1'b0;
         mem_req_val    <= 1'b0;
         mem_req_opaque <= '0;
      end else begin
         err <= (err & ~err_clr) | err_set;
         if (mem_req_val && mem_req_rdy)
            mem_req_opaque <= mem_req_opaque + 1'b1;
         case (state)
            IDLE: if (push_en && !err_set[2]) begin
               base   <= cmd.addr & 24'hFFFFFC;
               len_m1 <= CW'(cmd.len_m1);
               idx    <= '0;
               fcnt   <= '0;
               fin    <= 1'b0;
               state  <= cmd.rd ? RD_REQ : WR_DATA;
            end
            WR_DATA: if (push_en) begin
               wr_data <= push_msg;
               if (is_go)
                  state <= GO_SET;
               else if (is_stat) begin
                  if (last) state <= IDLE;
                  else idx <= idx + 1'b1;
               end else begin
                  mem_req_val <= 1'b1;
                  state       <= WR_REQ;
               end
            end
            GO_SET: begin
               go <= wr_data[0];
               if (last) state <= IDLE;
               else begin idx <= idx + 1'b1; state <= WR_DATA; end
            end
            WR_REQ: if (mem_req_rdy) begin
               mem_req_val <= 1'b0;
               if (last) state <= IDLE;
               else begin idx <= idx + 1'b1; state <= WR_DATA; end
            end
            // Request is raised one cycle after entry so the register-hit
            // decode sees the settled word index.
            RD_REQ: if (!mem_req_val) begin
               if (fin)
                  state <= IDLE;
               else if (is_go) begin
                  rd_buf <= {31'd0, go};
                  state  <= RD_HOLD;
               end else if (is_stat) begin
                  rd_buf <= {29'd0, err};
                  state  <= RD_HOLD;
               end else
                  mem_req_val <= 1'b1;
            end else if (mem_req_rdy) begin
               mem_req_val <= 1'b0;
               state       <= RD_RESP;
            end
            RD_RESP: if (mem_resp_val) begin
               rd_buf <= mem_resp_data;
               state  <= RD_HOLD;
            end
            RD_HOLD:
               if (fin)
                  state <= IDLE;
               else if (pull_en && !last) begin
                  idx   <= idx + 1'b1;
                  state <= RD_REQ;
               end
            default: state <= IDLE;
         endcase
         // The len-th read frame may end while a fetch is still in flight;
         // fin lets that fetch drain before returning to IDLE.
         if (push_en && rd_state) begin
            if (fcnt == len_m1) fin <= 1'b1;
            else fcnt <= fcnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench: bit-bangs SPI frames into spi_mem_bridge against a simple
// memory model with controllable ready and response delay.
module tb_spi_mem_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs = 1'b1, mosi = 1'b0, sclk = 1'b0;
   logic        miso;
   logic        req_val, req_rdy = 1'b1, req_op;
   logic [7:0]  req_opaque;
   logic [31:0] req_addr, req_data;
   logic [3:0]  req_strb;
   logic        resp_val = 1'b0, resp_rdy;
   logic [31:0] resp_data = '0;
   logic        go;
   logic [2:0]  err;

   int checks = 0;
   int fails  = 0;

   logic [31:0] mem [0:255];
   logic [31:0] wa [0:31];
   logic [31:0] wd [0:31];
   logic [3:0]  ws [0:31];
   int          wn = 0, nreq = 0, resp_dly = 0, pdly = 0;
   logic        pend = 1'b0;
   logic [31:0] pdata = '0;

   spi_mem_bridge dut (
      .clk(clk), .rst(rst), .cs(cs), .mosi(mosi), .sclk(sclk), .miso(miso),
      .mem_req_val(req_val), .mem_req_rdy(req_rdy), .mem_req_op(req_op),
      .mem_req_opaque(req_opaque), .mem_req_addr(req_addr),
      .mem_req_strb(req_strb), .mem_req_data(req_data),
      .mem_resp_val(resp_val), .mem_resp_rdy(resp_rdy),
      .mem_resp_data(resp_data), .go(go), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      resp_val <= 1'b0;
      if (pend) begin
         if (pdly == 0) begin
            resp_val  <= 1'b1;
            resp_data <= pdata;
            pend      <= 1'b0;
         end else
            pdly <= pdly - 1;
      end
      if (req_val && req_rdy) begin
         nreq <= nreq + 1;
         if (req_op) begin
            mem[req_addr[9:2]] <= req_data;
            wa[wn] <= req_addr;
            wd[wn] <= req_data;
            ws[wn] <= req_strb;
            wn     <= wn + 1;
         end else begin
            pend  <= 1'b1;
            pdly  <= resp_dly;
            pdata <= mem[req_addr[9:2]];
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_frame(input logic [31:0] tx, output logic [31:0] rx);
      rx = '0;
      cs = 1'b0;
      wait_clk(4);
      for (int i = 31; i >= 0; i--) begin
         mosi = tx[i];
         wait_clk(4);
         rx[i] = miso;
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
      wait_clk(4);
      cs = 1'b1;
      wait_clk(20);
   endtask

   task automatic test_reset;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
      checks++; if (go !== 1'b1) begin fails++; $display("FAIL reset_go: got %h want 1", go); end
      checks++; if (err !== 3'b000) begin fails++; $display("FAIL reset_err: got %h want 0", err); end
      checks++; if (req_val !== 1'b0) begin fails++; $display("FAIL reset_req_val: got %h want 0", req_val); end
      checks++; if (resp_rdy !== 1'b1) begin fails++; $display("FAIL reset_resp_rdy: got %h want 1", resp_rdy); end
   endtask

   task automatic test_write_burst;
      logic [31:0] rx;
      int w0;
      w0 = wn;
      spi_frame(32'h01000100, rx);
      checks++; if (rx !== 32'h0) begin fails++; $display("FAIL wr_idle_status: got %h want 0", rx); end
      spi_frame(32'h0000000A, rx);
      spi_frame(32'h0000000B, rx);
      wait_clk(5);
      checks++; if (wn - w0 !== 2) begin fails++; $display("FAIL wr_count: got %0d want 2", wn - w0); end
      checks++; if (wa[w0] !== 32'h100 || wd[w0] !== 32'hA) begin fails++; $display("FAIL wr_word0: got %h@%h want a@100", wd[w0], wa[w0]); end
      checks++; if (wa[w0+1] !== 32'h104 || wd[w0+1] !== 32'hB) begin fails++; $display("FAIL wr_word1: got %h@%h want b@104", wd[w0+1], wa[w0+1]); end
      checks++; if (ws[w0] !== 4'hF || ws[w0+1] !== 4'hF) begin fails++; $display("FAIL wr_strb: got %h %h want f f", ws[w0], ws[w0+1]); end
      checks++; if (err !== 3'b000) begin fails++; $display("FAIL wr_err: got %h want 0", err); end
   endtask

   task automatic test_go;
      logic [31:0] rx;
      int n0;
      n0 = nreq;
      spi_frame(32'h00000000, rx);
      spi_frame(32'h00000000, rx);
      checks++; if (go !== 1'b0) begin fails++; $display("FAIL go_clear: got %h want 0", go); end
      spi_frame(32'h80000000, rx);
      spi_frame(32'h00000000, rx);
      checks++; if (rx !== 32'h0) begin fails++; $display("FAIL go_readback0: got %h want 0", rx); end
      spi_frame(32'h00000000, rx);
      spi_frame(32'h00000001, rx);
      checks++; if (go !== 1'b1) begin fails++; $display("FAIL go_set: got %h want 1", go); end
      spi_frame(32'h80000000, rx);
      spi_frame(32'h00000000, rx);
      checks++; if (rx !== 32'h1) begin fails++; $display("FAIL go_readback1: got %h want 1", rx); end
      checks++; if (nreq !== n0) begin fails++; $display("FAIL go_no_mem: got %0d reqs want 0", nreq - n0); end
   endtask

   task automatic test_read_burst;
      logic [31:0] rx;
      logic [31:0] exp_w [0:2];
      int n0;
      exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
      mem[8'h80] = 32'h11; mem[8'h81] = 32'h22; mem[8'h82] = 32'h33;
      n0 = nreq;
      spi_frame(32'h82000200, rx);
      for (int k = 0; k < 3; k++) begin
         spi_frame(32'h0, rx);
         checks++; if (rx !== exp_w[k]) begin fails++; $display("FAIL rd_word%0d: got %h want %h", k, rx, exp_w[k]); end
      end
      checks++; if (err !== 3'b000) begin fails++; $display("FAIL rd_err: got %h want 0", err); end
      checks++; if (nreq - n0 !== 3) begin fails++; $display("FAIL rd_reqs: got %0d want 3", nreq - n0); end
   endtask

   task automatic test_overrun;
      logic [31:0] rx;
      int w0, n0;
      w0 = wn;
      req_rdy = 1'b0;
      spi_frame(32'h01000300, rx);
      spi_frame(32'h00000005, rx);
      checks++; if (req_val !== 1'b1) begin fails++; $display("FAIL ovr_stall: got %h want 1", req_val); end
      spi_frame(32'h00000006, rx);
      checks++; if (err !== 3'b001) begin fails++; $display("FAIL ovr_err: got %h want 1", err); end
      req_rdy = 1'b1;
      wait_clk(5);
      spi_frame(32'h00000007, rx);
      wait_clk(5);
      checks++; if (wn - w0 !== 2) begin fails++; $display("FAIL ovr_count: got %0d want 2", wn - w0); end
      checks++; if (wa[w0] !== 32'h300 || wd[w0] !== 32'h5) begin fails++; $display("FAIL ovr_word0: got %h@%h want 5@300", wd[w0], wa[w0]); end
      checks++; if (wa[w0+1] !== 32'h304 || wd[w0+1] !== 32'h7) begin fails++; $display("FAIL ovr_word1: got %h@%h want 7@304", wd[w0+1], wa[w0+1]); end
      n0 = nreq;
      spi_frame(32'h00000004, rx);
      spi_frame(32'h00000001, rx);
      checks++; if (err !== 3'b000) begin fails++; $display("FAIL ovr_clear: got %h want 0", err); end
      checks++; if (nreq !== n0) begin fails++; $display("FAIL ovr_stat_no_mem: got %0d reqs want 0", nreq - n0); end
   endtask

   task automatic test_underrun;
      logic [31:0] rx;
      resp_dly = 400;
      spi_frame(32'h80000200, rx);
      spi_frame(32'h0, rx);
      checks++; if (rx !== 32'hDEADBEEF) begin fails++; $display("FAIL und_word: got %h want deadbeef", rx); end
      checks++; if (err !== 3'b010) begin fails++; $display("FAIL und_err: got %h want 2", err); end
      wait_clk(400);
      resp_dly = 0;
      spi_frame(32'h80000004, rx);
      checks++; if (rx !== 32'h2) begin fails++; $display("FAIL und_idle_status: got %h want 2", rx); end
      spi_frame(32'h0, rx);
      checks++; if (rx !== 32'h2) begin fails++; $display("FAIL und_stat_read: got %h want 2", rx); end
      spi_frame(32'h00000004, rx);
      spi_frame(32'h00000002, rx);
      checks++; if (err !== 3'b000) begin fails++; $display("FAIL und_clear: got %h want 0", err); end
   endtask

   task automatic test_bad_len;
      logic [31:0] rx;
      int n0;
      n0 = nreq;
      spi_frame(32'h10000100, rx);
      checks++; if (err !== 3'b100) begin fails++; $display("FAIL len_err: got %h want 4", err); end
      spi_frame(32'h80000004, rx);
      checks++; if (rx !== 32'h4) begin fails++; $display("FAIL len_still_idle: got %h want 4", rx); end
      spi_frame(32'h0, rx);
      checks++; if (rx !== 32'h4) begin fails++; $display("FAIL len_stat_read: got %h want 4", rx); end
      checks++; if (nreq !== n0) begin fails++; $display("FAIL len_no_mem: got %0d reqs want 0", nreq - n0); end
      spi_frame(32'h00000004, rx);
      spi_frame(32'h00000004, rx);
      checks++; if (err !== 3'b000) begin fails++; $display("FAIL len_clear: got %h want 0", err); end
   endtask

   task automatic test_reset_mid_burst;
      logic [31:0] rx;
      int n0;
      spi_frame(32'h00000000, rx);
      spi_frame(32'h00000000, rx);
      checks++; if (go !== 1'b0) begin fails++; $display("FAIL rst_pre_go: got %h want 0", go); end
      req_rdy = 1'b0;
      spi_frame(32'h03000400, rx);
      spi_frame(32'h00000009, rx);
      checks++; if (req_val !== 1'b1) begin fails++; $display("FAIL rst_pre_req: got %h want 1", req_val); end
      n0 = nreq;
      #2 rst = 1'b1;
      #1;
      checks++; if (req_val !== 1'b0) begin fails++; $display("FAIL rst_req_val: got %h want 0", req_val); end
      checks++; if (go !== 1'b1) begin fails++; $display("FAIL rst_go: got %h want 1", go); end
      wait_clk(3);
      rst = 1'b0;
      req_rdy = 1'b1;
      wait_clk(10);
      checks++; if (nreq !== n0) begin fails++; $display("FAIL rst_no_req: got %0d reqs want 0", nreq - n0); end
      spi_frame(32'h80000004, rx);
      checks++; if (rx !== 32'h0) begin fails++; $display("FAIL rst_idle: got %h want 0", rx); end
      spi_frame(32'h0, rx);
      checks++; if (rx !== 32'h0) begin fails++; $display("FAIL rst_stat: got %h want 0", rx); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      test_reset;
      test_write_burst;
      test_go;
      test_read_burst;
      test_overrun;
      test_underrun;
      test_bad_len;
      test_reset_mid_burst;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/spi_mem_bridge.md
SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

Interface
REQ-001 Parameter p_opaq_bits, default 8: width of mem request opaque field.
REQ-002 Parameter p_max_burst, default 16: maximum words per SPI transaction (power of two, 1..128).
REQ-003 Parameter p_go_addr, default 32'h00000000: address of the processor-enable register.
REQ-004 Parameter p_stat_addr, default 32'h00000004: address of the error-status register.
REQ-005 clk  input  1  system clock; the only clock.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 cs, mosi, sclk  input  1 each  SPI chip-select, data-in and clock, passed to an internal SPIMinion (nbits 32).
REQ-008 miso  output  1  SPI data-out from the SPIMinion.
REQ-009 mem  MemIntf.client  -  32-bit word memory port: req_val/req_rdy/req_msg{op,opaque,addr,strb,data}, resp_val/resp_rdy/resp_msg.
REQ-010 go  output  1  processor enable.
REQ-011 err  output  3  sticky errors: [0] overrun, [1] underrun, [2] bad length.

Function
REQ-012 SPIMinion push_en marks the end of an SPI frame (push_msg valid); pull_en marks the start of a frame (pull_msg sampled that cycle).
REQ-013 The first frame in IDLE is a command: [31] 1=read/0=write; [30:24] len-1; [23:0] byte address, word aligned (bits [1:0] ignored, treated as 0).
REQ-014 len-1 >= p_max_burst: set err[2], discard the command, remain in IDLE.
REQ-015 Address of word k = cmd addr + 4k; the command address is not latched a second time during a burst.
REQ-016 States: IDLE, WR_DATA, WR_REQ, GO_SET, RD_REQ, RD_RESP, RD_HOLD.
REQ-017 Write: IDLE -> WR_DATA; each push_en latches data -> WR_REQ; WR_REQ asserts req_val (op write, strb 4'b1111) until req_rdy -> WR_DATA, or -> IDLE after word len-1.
REQ-018 Write word to p_go_addr: GO_SET for 1 cycle, go <= data[0], no mem request. Write word to p_stat_addr: clear err bits where data bit is 1, no mem request.
REQ-019 push_en while in WR_REQ: set err[0], drop the word, word counter unchanged.
REQ-020 Read: IDLE -> RD_REQ; req_val (op read) until req_rdy -> RD_RESP; on resp_val, latch resp data into rd_buf -> RD_HOLD.
REQ-021 pull_msg = rd_buf; pull_en in RD_HOLD issues the read for the next word (-> RD_REQ), unless the current word is the last.
REQ-022 pull_en in RD_REQ/RD_RESP: set err[1]; pull_msg is 32'hDEADBEEF for that frame.
REQ-023 Read frames are counted by push_en, with MOSI content ignored; after the len-th read frame -> IDLE. Frames 1..len after the command return words 0..len-1.
REQ-024 Reads of p_go_addr return {31'b0, go} and reads of p_stat_addr return {29'b0, err}, with no mem request (RD_REQ -> RD_HOLD in 1 cycle).
REQ-025 Single outstanding request; mem.resp_rdy is tied to 1; write responses are ignored.
REQ-026 opaque = p_opaq_bits-bit counter, incremented on each accepted request.
REQ-027 In IDLE, pull_msg = {29'b0, err}.

Reset
REQ-028 rst asynchronously forces: state IDLE, go=1, err=0, rd_buf=0, counters=0, req_val=0. Reset mid-burst abandons the burst with no further requests.

Structure
REQ-029 Shared package holds the state enum and the command-field constants/typedef (op bit, len field, addr field).
REQ-030 One sub-module: SPIMinion, instantiated as-is; all other logic is flat.

Verification
REQ-031 Write cmd 0x01000100 (len 2), data 0xA, 0xB -> mem writes 0xA@0x100 and 0xB@0x104, strb 4'b1111, then IDLE.
REQ-032 Write cmd to addr 0, data 0x0 -> go falls to 0 with no mem request; data 0x1 -> go=1.
REQ-033 Read cmd 0x82000200 (len 3), mem preloaded 0x11/0x22/0x33 at 0x200/0x204/0x208 -> MISO frames 1..3 return 0x11, 0x22, 0x33; err=0.
REQ-034 req_rdy held low during a write burst while the next word arrives -> err[0]=1, the word is dropped; then a status write of 0x1 clears err[0].
REQ-035 Read cmd with resp delayed past the next frame start -> frame returns 0xDEADBEEF and err[1]=1.
REQ-036 Command with len-1 = p_max_burst -> err[2]=1, no mem traffic; assert rst mid-burst -> go=1, IDLE, req_val=0 immediately.
